kernel_stream_source: RTL and testbench
=======================================

KERNEL_STREAM_SOURCE -- requirements
Module: kernel_stream_source

Interface
REQ-001 The block SHALL have parameter STREAMW, default 32: data word width in bits.
REQ-002 The block SHALL have parameter NWORDSW, default 16: word-count width in bits.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; the ports SHALL be:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a stream; sampled in IDLE only.
- nwords  in  NWORDSW  number of words to emit; latched on accepted start.
- base  in  STREAMW  first word value; latched on accepted start.
- stride  in  STREAMW  increment between words; latched on accepted start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the stream completes.
- ovalid  out  1  out1_s0 holds a valid word.
- oready  in  1  downstream kernel (ivalid/iready side) accepts the word.
- out1_s0  out  STREAMW  stream data word.
- olast  out  1  qualifies the final word of the stream; meaningful only with ovalid.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.
REQ-005 In IDLE, start=1 with nwords!=0 SHALL latch nwords/base/stride, load out1_s0=base, and enter RUN next edge.
REQ-006 In IDLE, start=1 with nwords=0 SHALL enter DONE directly; ovalid SHALL NOT assert.
REQ-007 In IDLE and DONE, start SHALL be ignored except as in REQ-005/006; in RUN start SHALL be ignored.
REQ-008 ovalid SHALL equal (state==RUN); busy SHALL equal ovalid.
REQ-009 Latency: start sampled at edge T SHALL give ovalid=1 with out1_s0=base after edge T.
REQ-010 A transfer SHALL occur on any edge with ovalid=1 and oready=1.
REQ-011 While ovalid=1 and oready=0, out1_s0 and olast SHALL hold stable; ovalid SHALL NOT deassert.
REQ-012 On transfer k (k=0..nwords-1), the next word SHALL be base+(k+1)*stride, computed as running sum, modulo 2^STREAMW (wrap silently).
REQ-013 olast SHALL be 1 exactly while the word index equals nwords-1.
REQ-014 On transfer with olast=1, the FSM SHALL enter DONE; ovalid SHALL drop after that edge.
REQ-015 With oready held 1, the block SHALL sustain one transfer per cycle, no bubbles.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 The word counter SHALL be NWORDSW bits; nwords=2^NWORDSW-1 SHALL produce that many words without counter overflow.
REQ-018 oready while ovalid=0 SHALL have no effect.
REQ-019 Back-to-back streams: start may be accepted in the IDLE cycle right after DONE; minimum gap between streams is two cycles (DONE, IDLE).

Reset
REQ-020 rst=0 SHALL asynchronously force state IDLE, busy=0, done=0, ovalid=0, olast=0, out1_s0=0, counter=0, latched parameters=0.
REQ-021 Reset asserted mid-stream SHALL abort it immediately; no done pulse SHALL follow; after rst release the block SHALL sit in IDLE awaiting start.
REQ-022 First start SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-023 Basic: nwords=4, base=10, stride=3, oready=1 -> words 10,13,16,19 on four consecutive cycles, olast on 19, done pulse one cycle later.
REQ-024 Backpressure: nwords=3, base=0, stride=1, oready low 2 cycles at word 1 -> word 1 held stable with ovalid=1 for 3 cycles, sequence 0,1,2, no loss or duplication.
REQ-025 Zero length: nwords=0, start=1 -> no ovalid, done=1 exactly one cycle after start edge+1, busy stays 0.
REQ-026 Wrap: STREAMW=32, base=0xFFFFFFFE, stride=1, nwords=4 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-027 Reset mid-run: nwords=8, rst=0 after 3 transfers -> ovalid/out1_s0/olast/busy go 0 asynchronously, no done; a new start (nwords=2, base=5, stride=5) yields 5,10.
REQ-028 Start during RUN: start pulsed with different parameters while busy -> ignored; original stream completes unchanged.

Source files
------------

// File: rtl/kernel_stream_source_if.sv
// Output stream handshake bundle for kernel_stream_source.
//   ovalid  : producer has a word on out1_s0
//   oready  : consumer accepts the word this edge
//   out1_s0 : data word
//   olast   : marks the final word of a stream (qualified by ovalid)
interface kernel_stream_source_if #(
  parameter int STREAMW = 32
) ();
  logic               ovalid;
  logic               oready;
  logic [STREAMW-1:0] out1_s0;
  logic               olast;

  modport master (output ovalid, output out1_s0, output olast, input oready);
  modport slave  (input ovalid, input out1_s0, input olast, output oready);
endinterface

// File: rtl/kernel_stream_source.sv
// kernel_stream_source: emits an arithmetic sequence base, base+stride, ...
// of nwords words on a valid/ready stream, then pulses done for one cycle.
// Ports:
//   clk, rst (async, active low)
//   start, nwords, base, stride : stream request, sampled in IDLE
//   busy  : high while words are being offered
//   done  : one-cycle completion pulse
//   o     : output stream (ovalid/oready/out1_s0/olast)
module kernel_stream_source #(
  parameter int STREAMW = 32,
  parameter int NWORDSW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NWORDSW-1:0]  nwords,
  input  logic [STREAMW-1:0]  base,
  input  logic [STREAMW-1:0]  stride,
  output logic                busy,
  output logic                done,
  kernel_stream_source_if.master o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [NWORDSW-1:0] cnt_q, cnt_d;       // index of the word on out1_s0
  logic [NWORDSW-1:0] nwords_q, nwords_d;
  logic [STREAMW-1:0] stride_q, stride_d;
  logic [STREAMW-1:0] data_q, data_d;     // running sum, wraps silently
  logic               run;
  logic               is_last;

  assign run     = (state_q == RUN);
  // nwords_q is never zero in RUN, so nwords_q-1 cannot underflow there;
  // the index tops out at nwords-1 and so never overflows the counter.
  assign is_last = (cnt_q == (nwords_q - NWORDSW'(1)));

  assign o.ovalid  = run;
  assign o.olast   = run && is_last;
  assign o.out1_s0 = data_q;
  assign busy      = run;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nwords_d = nwords_q;
    stride_d = stride_q;
    data_d   = data_q;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nwords != '0) begin
            nwords_d = nwords;
            stride_d = stride;
            data_d   = base;
            cnt_d    = '0;
            state_d  = RUN;
          end else begin
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (o.oready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            cnt_d  = cnt_q + NWORDSW'(1);
            data_d = data_q + stride_q;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nwords_q <= '0;
      stride_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nwords_q <= nwords_d;
      stride_q <= stride_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_kernel_stream_source.sv
module tb_kernel_stream_source;
  localparam int SW = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] nwords = '0;
  logic [SW-1:0] base = '0;
  logic [SW-1:0] stride = '0;
  logic          busy, done;

  kernel_stream_source_if #(.STREAMW(SW)) oif ();

  kernel_stream_source #(.STREAMW(SW), .NWORDSW(NW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .nwords (nwords),
    .base   (base),
    .stride (stride),
    .busy   (busy),
    .done   (done),
    .o      (oif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // expected words: value and last flag
  typedef struct packed { logic [SW-1:0] d; logic last; } exp_t;
  exp_t q[$];

  int cyc = 0;
  int exp_done_cyc = -1;
  int exp_done = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // oready driver: forced value or random, applied shortly after each edge
  logic rand_ready = 1'b0;
  logic ready_force = 1'b1;
  initial begin
    forever begin
      oif.oready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
      @(posedge clk);
      #2;
    end
  end

  // monitor / scoreboard
  logic          stalled = 1'b0;
  logic [SW-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    chk("busy_eq_ovalid", {63'd0, busy}, {63'd0, oif.ovalid});
    if (stalled && oif.ovalid) chk("stall_hold_data", 64'(oif.out1_s0), 64'(held));
    stalled = oif.ovalid && !oif.oready;
    held    = oif.out1_s0;
    if (oif.ovalid && oif.oready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", oif.out1_s0);
      end else begin
        e = q.pop_front();
        chk("word_data", 64'(oif.out1_s0), 64'(e.d));
        chk("word_last", {63'd0, oif.olast}, {63'd0, e.last});
        xfer_cnt++;
        if (e.last) begin
          exp_done_cyc = cyc + 1;
          exp_done++;
        end
      end
    end
    if (done) begin
      chk("done_timing", 64'(cyc), 64'(exp_done_cyc));
      done_cnt++;
    end
  end

  // called just after a rising edge with the block in IDLE
  task automatic start_stream(input int n, input logic [SW-1:0] b, input logic [SW-1:0] s);
    start  = 1'b1;
    nwords = NW'(n);
    base   = b;
    stride = s;
    if (n == 0) begin
      exp_done_cyc = cyc + 1;
      exp_done++;
    end else begin
      for (int k = 0; k < n; k++) q.push_back('{d: b + s * SW'(k), last: (k == n - 1)});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n != 0) begin
      chk("first_ovalid", {63'd0, oif.ovalid}, 64'd1);
      chk("first_word", 64'(oif.out1_s0), 64'(b));
    end else begin
      chk("zero_ovalid", {63'd0, oif.ovalid}, 64'd0);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      chk("zero_done", {63'd0, done}, 64'd1);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || done_cnt != exp_done || busy) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("stream_timeout", {63'd0, (t < 3000)}, 64'd1);
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int x0, t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", {63'd0, oif.ovalid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_olast", {63'd0, oif.olast}, 64'd0);
    chk("rst_data", 64'(oif.out1_s0), 64'd0);

    // basic stream, start on first edge after reset release
    rst = 1'b1;
    start_stream(4, 10, 3);
    wait_idle();

    // backpressure on word 1
    start_stream(3, 0, 1);
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    chk("bp_word1", 64'(oif.out1_s0), 64'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'd0, oif.ovalid}, 64'd1);
      chk("bp_hold_word", 64'(oif.out1_s0), 64'd1);
    end
    ready_force = 1'b1;
    wait_idle();

    // zero length
    start_stream(0, 32'h55, 32'h1);
    wait_idle();

    // wrap
    start_stream(4, 32'hFFFF_FFFE, 1);
    wait_idle();

    // start pulsed while running must be ignored
    rand_ready = 1'b1;
    start_stream(6, 100, 7);
    chk("run_busy", {63'd0, busy}, 64'd1);
    start  = 1'b1;
    nwords = 2;
    base   = 999;
    stride = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    rand_ready = 1'b0;

    // reset mid-run
    x0 = xfer_cnt;
    start_stream(8, 1, 1);
    t = 0;
    while (xfer_cnt < x0 + 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("midrun_xfers", {63'd0, (t < 100)}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ovalid", {63'd0, oif.ovalid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_olast", {63'd0, oif.olast}, 64'd0);
    chk("arst_data", 64'(oif.out1_s0), 64'd0);
    q.delete();
    exp_done_cyc = -1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("arst_no_done", 64'(done_cnt), 64'(exp_done));
    rst = 1'b1;
    start_stream(2, 5, 5);
    wait_idle();

    // randomized streams
    rand_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      start_stream(int'($urandom_range(0, 9)), $urandom, $urandom);
      wait_idle();
    end
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
